// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the single-clock FIFO family.
//   - FIFO_STD / FIFO_FWFT : read-mode selectors for the FWFT parameter.
//   - count_width()        : width of pointers and occupancy count. It is one
//                            bit wider than the address so that a full FIFO
//                            (count == DEPTH) is representable.
// -----------------------------------------------------------------------------
package fifo_pkg;

    // Read-mode selectors.
    localparam int FIFO_STD  = 0;  // registered read, rvalid strobe
    localparam int FIFO_FWFT = 1;  // show-ahead, head word always visible

    // Pointer / count width for a given address width.
    function automatic int count_width(input int asize);
        return asize + 1;
    endfunction

endpackage : fifo_pkg

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
//   DEPTH x DSIZE storage for sync_fifo with one write port and one read port.
//   The read port is combinational when FWFT = FIFO_FWFT, otherwise the read
//   word is captured into a register on rd_en and held until the next rd_en.
//
// Ports
//   clk    in   clock, all state on posedge
//   rst    in   synchronous active-high reset (read register only)
//   wr_en  in   write strobe, stores wdata at waddr
//   waddr  in   [ASIZE-1:0] write address
//   wdata  in   [DSIZE-1:0] write data
//   rd_en  in   registered-mode read strobe, captures mem[raddr]
//   raddr  in   [ASIZE-1:0] read address
//   rdata  out  [DSIZE-1:0] read data (combinational or registered)
// -----------------------------------------------------------------------------
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4,
    parameter int FWFT  = FIFO_FWFT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rd_en,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [DSIZE-1:0] rdata_d;
    logic [DSIZE-1:0] rdata_q;

    // NOTE: the storage array has no reset on purpose; resetting it would turn
    // a compact RAM into DEPTH*DSIZE individually reset flops. Stale contents
    // are unobservable because the pointers are reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[waddr] <= wdata;
        end
    end

    // NOTE: combinational next-state logic assigns a default first so no
    // latch is inferred on paths where rd_en is low.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = mem_q[raddr];
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Mode is a constant, so only one leg survives synthesis.
    assign rdata = (FWFT == FIFO_FWFT) ? mem_q[raddr] : rdata_q;

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with selectable read mode (show-ahead or registered with
//   a valid strobe), an occupancy count, programmable almost-full /
//   almost-empty flags and single-cycle overflow / underflow pulses.
//
// Parameters
//   DSIZE         data width
//   ASIZE         address width, DEPTH = 1 << ASIZE
//   AFULL_LEVEL   walmost_full when count >= AFULL_LEVEL   (1..DEPTH)
//   AEMPTY_LEVEL  ralmost_empty when count <= AEMPTY_LEVEL (0..DEPTH-1)
//   FWFT          FIFO_FWFT (1) show-ahead, FIFO_STD (0) registered read
//
// Ports
//   clk            in   clock, all state on posedge
//   rst            in   synchronous active-high reset
//   wdata          in   write data
//   w_en           in   write request
//   r_en           in   read request
//   rdata          out  read data
//   rvalid         out  FWFT=0: one-cycle strobe for a popped word;
//                       FWFT=1: equals !rempty
//   wfull          out  count == DEPTH
//   rempty         out  count == 0
//   walmost_full   out  count >= AFULL_LEVEL
//   ralmost_empty  out  count <= AEMPTY_LEVEL
//   count          out  stored entries, 0..DEPTH
//   overflow       out  pulse: w_en seen while wfull
//   underflow      out  pulse: r_en seen while rempty
// -----------------------------------------------------------------------------
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DSIZE        = 8,
    parameter int ASIZE        = 4,
    parameter int AFULL_LEVEL  = 14,
    parameter int AEMPTY_LEVEL = 2,
    parameter int FWFT         = FIFO_FWFT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DSIZE-1:0]               wdata,
    input  logic                           w_en,
    input  logic                           r_en,
    output logic [DSIZE-1:0]               rdata,
    output logic                           rvalid,
    output logic                           wfull,
    output logic                           rempty,
    output logic                           walmost_full,
    output logic                           ralmost_empty,
    output logic [count_width(ASIZE)-1:0]  count,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int CW    = count_width(ASIZE);
    localparam int DEPTH = 1 << ASIZE;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    // Pointers carry a wrap bit above the memory index.
    logic [CW-1:0] wptr_d,  wptr_q;
    logic [CW-1:0] rptr_d,  rptr_q;
    logic [CW-1:0] count_d, count_q;
    logic          overflow_d,  overflow_q;
    logic          underflow_d, underflow_q;
    logic          rvalid_d,    rvalid_q;

    logic          full_w;
    logic          empty_w;
    logic          wr_acc;
    logic          rd_acc;

    // Flags come only from the registered count, so w_en / r_en never reach
    // a flag combinationally.
    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    // Acceptance uses the registered flags: when full, a simultaneous read is
    // still taken and the write is refused (and vice versa when empty).
    assign wr_acc = w_en && !full_w;
    assign rd_acc = r_en && !empty_w;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        if (wr_acc) begin
            wptr_d = wptr_q + ONE_C;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + ONE_C;
        end
        // Pointer difference modulo 2^CW gives 0..DEPTH; equivalent to
        // +1 on write-only, -1 on read-only and unchanged otherwise.
        count_d     = wptr_d - rptr_d;
        overflow_d  = w_en && full_w;
        underflow_d = r_en && empty_w;
        rvalid_d    = rd_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rvalid_q    <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rvalid_q    <= rvalid_d;
        end
    end

    // Reset is gated into the write strobe so a write requested in the reset
    // cycle is dropped rather than landing in memory.
    sync_fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE),
        .FWFT  (FWFT)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_acc && !rst),
        .waddr (wptr_q[ASIZE-1:0]),
        .wdata (wdata),
        .rd_en (rd_acc && !rst),
        .raddr (rptr_q[ASIZE-1:0]),
        .rdata (rdata)
    );

    assign count         = count_q;
    assign wfull         = full_w;
    assign rempty        = empty_w;
    assign walmost_full  = (count_q >= AFULL_C);
    // count is 0 after reset, so this is high out of reset for any level.
    assign ralmost_empty = (count_q <= AEMPTY_C);
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;
    assign rvalid        = (FWFT == FIFO_FWFT) ? !empty_w : rvalid_q;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
//   Two sync_fifo instances share clk/rst: dut_a in show-ahead mode and dut_b
//   in registered-read mode. A queue per instance holds the words the bench
//   expects to pop, and a model count tracks occupancy and flags.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int DEPTH = 16;
    localparam int AFULL = 14;
    localparam int AEMPT = 2;

    logic       clk;
    logic       rst;

    logic [7:0] wdata_a, rdata_a;
    logic       w_en_a, r_en_a, rvalid_a, wfull_a, rempty_a, afull_a, aempty_a;
    logic       ovf_a, unf_a;
    logic [4:0] count_a;

    logic [7:0] wdata_b, rdata_b;
    logic       w_en_b, r_en_b, rvalid_b, wfull_b, rempty_b, afull_b, aempty_b;
    logic       ovf_b, unf_b;
    logic [4:0] count_b;

    int         total = 0;
    int         bad   = 0;

    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];
    int         cnt_a = 0;
    int         cnt_b = 0;
    logic [7:0] last_b = 8'h00;

    sync_fifo #(.DSIZE(8), .ASIZE(4), .AFULL_LEVEL(AFULL), .AEMPTY_LEVEL(AEMPT), .FWFT(1)) dut_a (
        .clk(clk), .rst(rst), .wdata(wdata_a), .w_en(w_en_a), .r_en(r_en_a),
        .rdata(rdata_a), .rvalid(rvalid_a), .wfull(wfull_a), .rempty(rempty_a),
        .walmost_full(afull_a), .ralmost_empty(aempty_a), .count(count_a),
        .overflow(ovf_a), .underflow(unf_a)
    );

    sync_fifo #(.DSIZE(8), .ASIZE(4), .AFULL_LEVEL(AFULL), .AEMPTY_LEVEL(AEMPT), .FWFT(0)) dut_b (
        .clk(clk), .rst(rst), .wdata(wdata_b), .w_en(w_en_b), .r_en(r_en_b),
        .rdata(rdata_b), .rvalid(rvalid_b), .wfull(wfull_b), .rempty(rempty_b),
        .walmost_full(afull_b), .ralmost_empty(aempty_b), .count(count_b),
        .overflow(ovf_b), .underflow(unf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_state(input string tag, input int m_cnt, input bit e_ovf, input bit e_unf,
                             input logic [4:0] a_cnt, input logic a_full, input logic a_empty,
                             input logic a_af, input logic a_ae, input logic a_ovf, input logic a_unf);
        check({tag, ".count"},  int'(a_cnt),   m_cnt);
        check({tag, ".wfull"},  int'(a_full),  int'(m_cnt == DEPTH));
        check({tag, ".rempty"}, int'(a_empty), int'(m_cnt == 0));
        check({tag, ".afull"},  int'(a_af),    int'(m_cnt >= AFULL));
        check({tag, ".aempty"}, int'(a_ae),    int'(m_cnt <= AEMPT));
        check({tag, ".ovf"},    int'(a_ovf),   int'(e_ovf));
        check({tag, ".unf"},    int'(a_unf),   int'(e_unf));
    endtask

    // One clock for both instances. Inputs are driven 1 time unit after the
    // previous edge; outputs are sampled 1 time unit after this edge.
    task automatic step(input logic wa, input logic ra, input logic [7:0] da,
                        input logic wb, input logic rb, input logic [7:0] db);
        bit         wa_ok, ra_ok, wb_ok, rb_ok;
        bit         e_ovf_a, e_unf_a, e_ovf_b, e_unf_b;
        logic [7:0] exp_a, pop_b;
        w_en_a = wa; r_en_a = ra; wdata_a = da;
        w_en_b = wb; r_en_b = rb; wdata_b = db;
        e_ovf_a = wa && (cnt_a == DEPTH);
        e_unf_a = ra && (cnt_a == 0);
        wa_ok   = wa && (cnt_a != DEPTH);
        ra_ok   = ra && (cnt_a != 0);
        e_ovf_b = wb && (cnt_b == DEPTH);
        e_unf_b = rb && (cnt_b == 0);
        wb_ok   = wb && (cnt_b != DEPTH);
        rb_ok   = rb && (cnt_b != 0);
        pop_b   = 8'h00;
        // Show-ahead: the word being popped is visible before the edge.
        if (ra_ok) begin
            exp_a = sb_a.pop_front();
            check("a.pop", int'(rdata_a), int'(exp_a));
        end
        if (wa_ok) sb_a.push_back(da);
        if (rb_ok) pop_b = sb_b.pop_front();
        if (wb_ok) sb_b.push_back(db);
        @(posedge clk);
        #1;
        cnt_a = cnt_a + int'(wa_ok) - int'(ra_ok);
        cnt_b = cnt_b + int'(wb_ok) - int'(rb_ok);
        chk_state("a", cnt_a, e_ovf_a, e_unf_a, count_a, wfull_a, rempty_a, afull_a, aempty_a, ovf_a, unf_a);
        check("a.rvalid", int'(rvalid_a), int'(cnt_a != 0));
        chk_state("b", cnt_b, e_ovf_b, e_unf_b, count_b, wfull_b, rempty_b, afull_b, aempty_b, ovf_b, unf_b);
        if (rb_ok) begin
            check("b.rvalid", int'(rvalid_b), 1);
            check("b.rdata", int'(rdata_b), int'(pop_b));
            last_b = pop_b;
        end else begin
            check("b.rvalid", int'(rvalid_b), 0);
            check("b.hold", int'(rdata_b), int'(last_b));
        end
    endtask

    // Synchronous reset for one edge, optionally with a write request on
    // dut_a that must be discarded.
    task automatic do_reset(input logic wa);
        rst = 1'b1;
        w_en_a = wa; r_en_a = 1'b0; wdata_a = 8'hEE;
        w_en_b = 1'b0; r_en_b = 1'b0; wdata_b = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        w_en_a = 1'b0;
        sb_a.delete();
        sb_b.delete();
        cnt_a = 0;
        cnt_b = 0;
        last_b = 8'h00;
        chk_state("rst.a", 0, 1'b0, 1'b0, count_a, wfull_a, rempty_a, afull_a, aempty_a, ovf_a, unf_a);
        chk_state("rst.b", 0, 1'b0, 1'b0, count_b, wfull_b, rempty_b, afull_b, aempty_b, ovf_b, unf_b);
        check("rst.a.rvalid", int'(rvalid_a), 0);
        check("rst.b.rvalid", int'(rvalid_b), 0);
        check("rst.b.rdata",  int'(rdata_b),  0);
    endtask

    initial begin
        logic [7:0] d;
        rst = 1'b0;
        w_en_a = 1'b0; r_en_a = 1'b0; wdata_a = 8'h00;
        w_en_b = 1'b0; r_en_b = 1'b0; wdata_b = 8'h00;
        #2;
        do_reset(1'b0);

        // Fill dut_a with 0x00..0x0F, then one write too many.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

        // Drain 16 words in order, then one read too many on both.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00);

        // Both requested while empty: write taken, read refused.
        step(1'b1, 1'b1, 8'h50, 1'b1, 1'b1, 8'h60);

        // Top dut_a up to full, then both requested while full.
        for (int i = 1; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h50 + i), 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        while (cnt_a != 0) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);

        // Registered read: drain dut_b, then 0xA5 write, read, idle.
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
        check("b.a5", int'(rdata_b), 8'hA5);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

        // Steady count of 3 with concurrent traffic across pointer wraps.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b1, 1'b0, 8'(8'hD0 + i));
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom_range(0, 255));
            step(1'b1, 1'b1, d, 1'b1, 1'b1, ~d);
        end
        check("wrap.a.count", int'(count_a), 3);
        check("wrap.b.count", int'(count_b), 3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00);

        // Mid-operation reset at count 7 with a write pending.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 1'b0, 8'h00);
        do_reset(1'b1);
        step(1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h4B);
        check("post_rst.a.rdata", int'(rdata_a), 8'h3C);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sync_fifo
